// File: rtl/bcd_display_scanner_if.sv
// Host/display bundle for the BCD digit scanner.
// The host drives load data; the scanner drives the decoder side.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank_lz;
  logic [3:0]              dig_bcd;
  logic                    dig_rbi_n;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport master (
    output load, bcd_in, blank_lz,
    input  dig_bcd, dig_rbi_n, dig_sel, frame_done
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output dig_bcd, dig_rbi_n, dig_sel, frame_done
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Multiplexed digit scanner feeding a 74LS47-style decoder.
// New words take effect only at frame wrap to avoid tearing.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input logic                    clk,
  input logic                    rst,
  bcd_display_scanner_if.slave   bus
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [IW-1:0] IDX_MSD = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(REFRESH_DIV - 1);

  logic [W-1:0]  r_active;
  logic          r_active_blank;
  logic [W-1:0]  r_pend;
  logic          r_pend_blank;
  logic          r_pend_valid;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_hz;

  logic       w_last;
  logic       w_wrap;
  logic [3:0] w_digit;

  // Digit-hold expiry, frame wrap and the digit now on display.
  always_comb begin
    w_last  = (r_cnt == CNT_TOP);
    w_wrap  = w_last && (r_idx == '0);
    w_digit = r_active[{r_idx, 2'b00} +: 4];
  end

  // Scan counters, higher-zero tracking and double-buffered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active       <= '0;
      r_active_blank <= 1'b0;
      r_pend         <= '0;
      r_pend_blank   <= 1'b0;
      r_pend_valid   <= 1'b0;
      r_cnt          <= '0;
      r_idx          <= IDX_MSD;
      r_hz           <= 1'b1;
    end else begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_last) begin
        if (r_idx == '0) begin
          r_idx <= IDX_MSD;
          r_hz  <= 1'b1;
        end else begin
          r_idx <= r_idx - IW'(1);
          r_hz  <= r_hz && (w_digit == 4'd0);
        end
      end

      if (w_wrap) begin
        // A load on the wrap cycle bypasses the pending buffer.
        if (bus.load) begin
          r_active       <= bus.bcd_in;
          r_active_blank <= bus.blank_lz;
          r_pend_valid   <= 1'b0;
        end else if (r_pend_valid) begin
          r_active       <= r_pend;
          r_active_blank <= r_pend_blank;
          r_pend_valid   <= 1'b0;
        end
      end else if (bus.load) begin
        r_pend       <= bus.bcd_in;
        r_pend_blank <= bus.blank_lz;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only; the LSD is never blanked.
  always_comb begin
    bus.dig_sel    = NUM_DIGITS'(1) << r_idx;
    bus.dig_bcd    = w_digit;
    bus.dig_rbi_n  = !(r_active_blank && r_hz && (r_idx != '0));
    bus.frame_done = w_wrap;
  end
endmodule
